// File: rtl/seq_alu.sv
// seq_alu: registered, handshaked ALU with valid/ready on both sides.
// Single-cycle ops (op[4]=0) complete one cycle after acceptance.
// Multi-cycle ops (op[4]=1) use an iterative shift-add multiplier and a
// restoring divider. Each takes WIDTH steps, so a result appears WIDTH+1
// cycles after acceptance.
// Optional feature macro: SEQ_ALU_SIGNED_MULDIV_EN adds the signed MULH, DIV
// and REM ops. Without the macro those codes are decoded as illegal.
// WIDTH must be at least 4 and a power of two.
module seq_alu #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             less,
    output logic             illegal
);

    localparam int              W2        = 2 * WIDTH;
    localparam logic [SHW-1:0]  LAST_STEP = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             less_q, less_d;
    logic             illegal_q, illegal_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [W2-1:0]    acc_q, acc_d;
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
    logic             neg_q, neg_d;
    logic             a_neg_q, a_neg_d;
    logic             sgn_op;
`endif

    logic             accept;
    logic             mc_legal;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_less;
    logic             alu_illegal;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [W2-1:0]    mul_next;
    logic [WIDTH:0]   rem_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [W2-1:0]    div_next;
    logic [W2-1:0]    step_acc;
    logic [WIDTH-1:0] fin_lo;
    logic [WIDTH-1:0] fin_hi;
    logic             hi_sel;
    logic [WIDTH-1:0] fin_res;

    assign in_ready  = rst_n & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = ~|result_q;
    assign less      = less_q;
    assign illegal   = illegal_q;

    // Single-cycle ALU: every 4-bit code with op[4]=0 is a legal operation.
    always_comb begin
        alu_res     = '0;
        alu_less    = 1'b0;
        alu_illegal = 1'b0;
        shamt       = datab[SHW-1:0];
        if (op[4]) begin
            alu_illegal = 1'b1;
        end else begin
            case (op[3:0])
                4'b0000: alu_res = dataa + datab;
                4'b1000: alu_res = dataa - datab;
                4'b0010: begin
                    alu_less = ($signed(dataa) < $signed(datab));
                    alu_res  = {{(WIDTH-1){1'b0}}, alu_less};
                end
                4'b1010: begin
                    alu_less = (dataa < datab);
                    alu_res  = {{(WIDTH-1){1'b0}}, alu_less};
                end
                4'b0001, 4'b1001: alu_res = dataa << shamt;
                4'b0101:          alu_res = dataa >> shamt;
                4'b1101:          alu_res = $unsigned($signed(dataa) >>> shamt);
                4'b0011, 4'b1011: alu_res = datab;
                4'b0100, 4'b1100: alu_res = dataa ^ datab;
                4'b0110, 4'b1110: alu_res = dataa | datab;
                default:          alu_res = dataa & datab;
            endcase
        end
    end

    // Recognise multi-cycle codes and prepare the operands loaded at acceptance.
    always_comb begin
        case (op)
            5'b10000, 5'b10001, 5'b10100, 5'b10101: mc_legal = 1'b1;
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
            5'b10010, 5'b10110, 5'b10111:           mc_legal = 1'b1;
`endif
            default:                                mc_legal = 1'b0;
        endcase
        mag_a = dataa;
        mag_b = datab;
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
        // Signed ops are the only multi-cycle codes with op[1] set.
        sgn_op = op[1];
        if (sgn_op && dataa[WIDTH-1]) begin
            mag_a = ~dataa + 1'b1;
        end
        if (sgn_op && datab[WIDTH-1]) begin
            mag_b = ~datab + 1'b1;
        end
`endif
    end

    // One shift-add (multiply) or restore-subtract (divide) step on the accumulator.
    always_comb begin
        mul_sum  = {1'b0, acc_q[W2-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        rem_sh   = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
        div_ge   = (rem_sh >= {1'b0, opb_q});
        div_diff = rem_sh[WIDTH-1:0] - opb_q;
        div_next = {(div_ge ? div_diff : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
        step_acc = op_q[2] ? div_next : mul_next;
    end

    // Select the final half and apply sign correction on the last step.
    always_comb begin
        fin_lo = step_acc[WIDTH-1:0];
        fin_hi = step_acc[W2-1:WIDTH];
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
        if (op_q[1]) begin
            if (!op_q[2]) begin
                if (neg_q) begin
                    {fin_hi, fin_lo} = ~step_acc + 1'b1;
                end
            end else begin
                if (neg_q) begin
                    fin_lo = ~step_acc[WIDTH-1:0] + 1'b1;
                end
                if (a_neg_q) begin
                    fin_hi = ~step_acc[W2-1:WIDTH] + 1'b1;
                end
            end
        end
`endif
        hi_sel  = op_q[2] ? op_q[0] : (op_q[0] | op_q[1]);
        fin_res = hi_sel ? fin_hi : fin_lo;
    end

    // Next-state logic for the IDLE/BUSY/DONE controller and datapath registers.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        less_d    = less_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
        neg_d     = neg_q;
        a_neg_d   = a_neg_q;
`endif
        case (state_q)
            BUSY: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d   = DONE;
                    result_d  = fin_res;
                    less_d    = 1'b0;
                    illegal_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
            end
        endcase
        if (accept) begin
            if (mc_legal) begin
                state_d = BUSY;
                op_d    = op[2:0];
                opb_d   = mag_b;
                acc_d   = {{WIDTH{1'b0}}, mag_a};
                cnt_d   = '0;
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
                // A zero divisor keeps the all-ones quotient uncorrected.
                neg_d   = sgn_op & (dataa[WIDTH-1] ^ datab[WIDTH-1]) & (|datab);
                a_neg_d = sgn_op & dataa[WIDTH-1];
`endif
            end else begin
                state_d   = DONE;
                result_d  = alu_res;
                less_d    = alu_less;
                illegal_d = alu_illegal;
            end
        end
    end

    // State and datapath registers; reset discards any in-flight work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            result_q  <= '0;
            less_q    <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            op_q      <= '0;
            opb_q     <= '0;
            acc_q     <= '0;
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
            neg_q     <= 1'b0;
            a_neg_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            less_q    <= less_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            opb_q     <= opb_d;
            acc_q     <= acc_d;
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
            neg_q     <= neg_d;
            a_neg_q   <= a_neg_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu with a behavioural reference model.
// Honours SEQ_ALU_SIGNED_MULDIV_EN in the same way as the design.
module tb_seq_alu;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         less;
        logic         ill;
        int           lat;
        int           acc_cycle;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   op;
    logic [W-1:0] dataa;
    logic [W-1:0] datab;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         less;
    logic         illegal;

    logic         rdy_rand_mode = 1'b0;
    logic         rdy_force = 1'b1;
    logic         rdy_rnd = 1'b1;

    int           total = 0;
    int           bad = 0;
    int           cycle = 0;
    bit           lat_done = 0;
    exp_t         scoreboard[$];

    assign out_ready = rdy_rand_mode ? rdy_rnd : rdy_force;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .dataa     (dataa),
        .datab     (datab),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .less      (less),
        .illegal   (illegal)
    );

    // Free-running clock and cycle counter.
    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    // Random consumer backpressure, only used when rdy_rand_mode is set.
    initial forever begin
        @(posedge clk);
        #1;
        rdy_rnd = ($urandom_range(0, 3) != 0);
    end

    // Hard stop in case something wedges outside a bounded wait.
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got no completion, want completion");
        $fatal(1, "[TB] global timeout");
    end

    // One comparison: counts it and reports a failure on mismatch.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference model computed straight from the arithmetic meaning of each op.
    function automatic exp_t model(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        logic [63:0]  prod;
        logic [63:0]  tmp;
        longint       sa;
        longint       sbv;
        int unsigned  sh;
        e.res       = '0;
        e.less      = 1'b0;
        e.ill       = 1'b0;
        e.lat       = 1;
        e.acc_cycle = 0;
        sh   = b % W;
        prod = {32'b0, a} * {32'b0, b};
        sa   = longint'($signed(a));
        sbv  = longint'($signed(b));
        tmp  = '0;
        if (!o[4]) begin
            casez (o[3:0])
                4'b0000: e.res = a + b;
                4'b1000: e.res = a - b;
                4'b0010: begin e.less = (sa < sbv); e.res = {31'b0, e.less}; end
                4'b1010: begin e.less = (a < b);    e.res = {31'b0, e.less}; end
                4'b?001: e.res = a << sh;
                4'b0101: e.res = a >> sh;
                4'b1101: begin tmp = sa >>> sh; e.res = tmp[W-1:0]; end
                4'b?011: e.res = b;
                4'b?100: e.res = a ^ b;
                4'b?110: e.res = a | b;
                default: e.res = a & b;
            endcase
        end else begin
            e.lat = W + 1;
            case (o)
                5'b10000: e.res = prod[W-1:0];
                5'b10001: e.res = prod[2*W-1:W];
                5'b10100: e.res = (b == 0) ? '1 : a / b;
                5'b10101: e.res = (b == 0) ? a : a % b;
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
                5'b10010: begin tmp = sa * sbv; e.res = tmp[2*W-1:W]; end
                5'b10110: begin
                    if (b == 0) e.res = '1;
                    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.res = a;
                    else begin tmp = sa / sbv; e.res = tmp[W-1:0]; end
                end
                5'b10111: begin
                    if (b == 0) e.res = a;
                    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.res = '0;
                    else begin tmp = sa % sbv; e.res = tmp[W-1:0]; end
                end
`endif
                default: begin
                    e.ill = 1'b1;
                    e.lat = 1;
                    e.res = '0;
                end
            endcase
        end
        return e;
    endfunction

    function automatic logic [W-1:0] randOperand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'd1;
            2:       return '1;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return $urandom_range(0, 255);
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [4:0] randOp();
        logic [4:0] mc [7] = '{5'd16, 5'd17, 5'd20, 5'd21, 5'd18, 5'd22, 5'd23};
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: return {1'b0, 4'($urandom_range(0, 15))};
            5, 6, 7:       return mc[$urandom_range(0, 6)];
            default:       return 5'($urandom_range(16, 31));
        endcase
    endfunction

    // Drive a request from posedge+1 and hold it until accepted; expectation goes to the scoreboard.
    task automatic applyStimulus(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        bit   done = 0;
        op       = o;
        dataa    = a;
        datab    = b;
        in_valid = 1'b1;
        e = model(o, a, b);
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.acc_cycle = cycle;
                scoreboard.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("accept_within_bound", {63'b0, done}, 64'd1);
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (scoreboard.size() == 0) ok = 1;
        end
        checkOutput("drain_within_bound", {63'b0, ok}, 64'd1);
    endtask

    // Monitor: checks latency on first presentation and contents on each transfer.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            lat_done = 0;
        end else if (out_valid) begin
            if (scoreboard.size() == 0) begin
                checkOutput("unexpected_out_valid", {63'b0, out_valid}, 64'd0);
            end else begin
                if (!lat_done) begin
                    checkOutput("latency", 64'(cycle - scoreboard[0].acc_cycle), 64'(scoreboard[0].lat));
                    lat_done = 1;
                end
                if (out_ready) begin
                    checkOutput("result",  64'(result),  64'(scoreboard[0].res));
                    checkOutput("less",    64'(less),    64'(scoreboard[0].less));
                    checkOutput("illegal", 64'(illegal), 64'(scoreboard[0].ill));
                    checkOutput("zero",    64'(zero),    64'(scoreboard[0].res == 0));
                    void'(scoreboard.pop_front());
                    lat_done = 0;
                end
            end
        end
    end

    // Directed scenarios followed by a randomized stream.
    initial begin
        bit   seen;
        int   busy_high;
        int   late;
        exp_t bp;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        op       = '0;
        dataa    = '0;
        datab    = '0;
        #12;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_result",    64'(result),    64'd0);
        checkOutput("rst_zero",      64'(zero),      64'd1);
        checkOutput("rst_less",      64'(less),      64'd0);
        checkOutput("rst_illegal",   64'(illegal),   64'd0);
        checkOutput("rst_in_ready",  64'(in_ready),  64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        $display("[TB] add and compares");
        applyStimulus(5'b00000, 32'h7FFF_FFFF, 32'd1);
        applyStimulus(5'b00010, 32'hFFFF_FFFF, 32'd1);
        applyStimulus(5'b01010, 32'hFFFF_FFFF, 32'd1);
        in_valid = 1'b0;
        drain();

        $display("[TB] multiply with operand churn during busy");
        applyStimulus(5'b10000, 32'hFFFF_FFFF, 32'd2);
        in_valid  = 1'b0;
        busy_high = 0;
        seen      = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            dataa = $urandom();
            datab = $urandom();
            op    = 5'b10001;
            @(negedge clk);
            if (out_valid) seen = 1;
            else if (in_ready) busy_high++;
            @(posedge clk);
            #1;
        end
        checkOutput("busy_in_ready_cycles", 64'(busy_high), 64'd0);
        checkOutput("mul_result_seen",      {63'b0, seen},  64'd1);
        applyStimulus(5'b10001, 32'hFFFF_FFFF, 32'd2);
        in_valid = 1'b0;
        drain();

        $display("[TB] divide");
        applyStimulus(5'b10100, 32'd100, 32'd7);
        applyStimulus(5'b10101, 32'd100, 32'd7);
        applyStimulus(5'b10100, 32'h1234, 32'd0);
        applyStimulus(5'b10101, 32'h1234, 32'd0);
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
        applyStimulus(5'b10010, 32'hFFFF_FFFF, 32'd2);
        applyStimulus(5'b10110, 32'h8000_0000, 32'hFFFF_FFFF);
        applyStimulus(5'b10111, 32'h8000_0000, 32'hFFFF_FFFF);
        applyStimulus(5'b10110, 32'hFFFF_FFF9, 32'd0);
        applyStimulus(5'b10111, 32'hFFFF_FFF9, 32'd2);
`endif
        in_valid = 1'b0;
        drain();

        $display("[TB] backpressure then back-to-back xor");
        rdy_force = 1'b0;
        bp = model(5'b00000, 32'h10, 32'h20);
        applyStimulus(5'b00000, 32'h10, 32'h20);
        in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        checkOutput("bp_result_seen", {63'b0, seen}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk);
            checkOutput("bp_hold_result",   64'(result),    64'(bp.res));
            checkOutput("bp_hold_valid",    64'(out_valid), 64'd1);
            checkOutput("bp_hold_in_ready", 64'(in_ready),  64'd0);
        end
        @(posedge clk);
        #1;
        rdy_force = 1'b1;
        applyStimulus(5'b00100, 32'h0000_F0F0, 32'h0000_0FF0);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b_no_bubble", 64'(out_valid), 64'd1);
        checkOutput("b2b_xor",       64'(result),    64'h0000_FF00);
        @(posedge clk);
        #1;
        drain();

        $display("[TB] reset during busy, then illegal op");
        applyStimulus(5'b10100, 32'd1000, 32'd3);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_zero",      64'(zero),      64'd1);
        checkOutput("midrst_in_ready",  64'(in_ready),  64'd0);
        scoreboard.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        late = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) late++;
        end
        checkOutput("no_late_result", 64'(late), 64'd0);
        @(posedge clk);
        #1;
        applyStimulus(5'b11000, 32'h55, 32'hAA);
        in_valid = 1'b0;
        drain();

        $display("[TB] random stream");
        rdy_rand_mode = 1'b1;
        for (int n = 0; n < 150; n++) begin
            applyStimulus(randOp(), randOperand(), randOperand());
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        in_valid      = 1'b0;
        rdy_rand_mode = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered, handshaked successor to the single-cycle 32-bit ALU.
- Executes the full single-cycle ALU op set with 1-cycle latency.
- Adds iterative shift-add multiply and restoring divide, taking WIDTH cycles each.
- Sits between the decode/issue stage and writeback. Uses valid/ready on both sides so the multi-cycle ops can stall issue.

Parameters:
- WIDTH, 32: operand/result width in bits. Must be ≥ 4 and a power of two.
- SHW, $clog2(WIDTH): shift-amount bits, taken from datab[SHW-1:0]. Derived; do not override.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request this cycle.
- op  input  5  operation code (see Behaviour).
- dataa  input  WIDTH  operand A.
- datab  input  WIDTH  operand B.
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  WIDTH  operation result.
- zero  output  1  1 when result == 0.
- less  output  1  compare outcome for SLT/SLTU, 0 for all other ops.
- illegal  output  1  op code was not recognised.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=0 while reset is asserted, out_valid=0, result=0, zero=1, less=0, illegal=0, iteration counter=0. In-flight work is discarded.
- After reset release: in_ready=1 in IDLE.
- Single-cycle ops, op[4]=0, op[3:0] as ALUctr:
  - 0000 ADD; 1000 SUB; 0010 SLT (signed); 1010 SLTU.
  - x001 SLL; 0101 SRL; 1101 SRA.
  - x011 COPYB; x100 XOR; x110 OR; x111 AND.
  - 1100, 1110, 1111 are legal aliases of XOR/OR/AND (x don't-care).
  - SLT/SLTU: result = {0..., less}, less = comparison outcome.
- Multi-cycle ops, op[4]=1:
  - 10000 MUL: low WIDTH bits of the product.
  - 10001 MULHU: high WIDTH bits of the unsigned product.
  - 10100 DIVU: quotient.
  - 10101 REMU: remainder.
- Any other op: result=0, illegal=1, latency 1.
- FSM states: IDLE, BUSY, DONE.
  - IDLE & in_valid & in_ready:
    - Single-cycle or illegal op: compute and register, go to DONE next cycle (latency 1).
    - Multi-cycle op: latch operands, counter=0, go to BUSY.
  - BUSY: one shift-add or restore-subtract step per cycle. After WIDTH steps, go to DONE with result registered. Accept-to-out_valid latency = WIDTH+1 cycles.
  - DONE: out_valid=1. Result, zero, less and illegal stay stable until out_ready=1.
    - Plain handshake: go to IDLE.
    - Back-to-back: if out_ready & in_valid in DONE with a single-cycle op, accept directly (in_ready = out_ready in DONE) and stay in DONE with the new result.
  - in_ready = (state==IDLE) | (state==DONE & out_ready). It is 0 in BUSY.
- Handshake rules:
  - Inputs are sampled only on an in_valid & in_ready cycle. Operand changes during BUSY have no effect.
  - in_valid may drop without acceptance; no state change results.
- Width/arithmetic rules:
  - All add/sub results are modulo 2^WIDTH.
  - Shifts use datab[SHW-1:0] only.
  - Multiply uses a 2*WIDTH-bit accumulator.
- Divide by zero: DIVU result = all ones; REMU result = dataa. Still takes WIDTH+1 cycles, illegal=0.
- zero is always computed from the registered result, for every op.
- Reset asserted mid-BUSY or in DONE: immediate return to the reset values; no out_valid pulse follows.

Optional Feature:
- Macro: SEQ_ALU_SIGNED_MULDIV_EN.
- Defined: adds 10010 MULH (signed×signed, high half), 10110 DIV (signed) and 10111 REM (signed).
  - Operands are converted to magnitudes, the result is sign-corrected in the final cycle, latency unchanged.
  - DIV by 0 → all ones; REM by 0 → dataa.
  - DIV of most-negative by −1 → most-negative; REM of the same → 0.
- Undefined: those three codes are illegal (result=0, illegal=1, latency 1), and no sign-correction logic is built.

Test Plan:
- ADD 0x7FFFFFFF + 1, op=00000, out_ready=1 → out_valid one cycle after accept, result=0x80000000, zero=0, less=0.
- SLT: dataa=0xFFFFFFFF, datab=1, op=00010 → result=1, less=1. SLTU with the same operands, op=01010 → result=0, less=0, zero=1.
- MUL/MULHU: 0xFFFFFFFF × 2, op=10000 → result=0xFFFFFFFE after exactly 33 cycles, in_ready=0 throughout BUSY. Same operands with op=10001 → result=0x00000001.
- Divide: DIVU 100/7 → 14; REMU → 2. DIVU x/0 with x=0x1234 → 0xFFFFFFFF; REMU x/0 → 0x1234.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → result stable, in_ready=0. Then out_ready=1 with a valid XOR request the same cycle → accepted, next result on the next cycle, no bubble.
- Reset and illegal op: assert rst_n=0 at BUSY step 10 → out_valid=0, zero=1 immediately, no late result. Then op=11000 → illegal=1, result=0, latency 1.
